// File: rtl/router_alloc_3port.sv
// router_alloc_3port
//   Output allocator for a 3-input / 3-output wormhole router slice.
//   Each free output is locked to one requesting input, chosen round-robin.
//   The lock holds until that input's tail flit crosses the output.
//   Per-output credit counters track the free downstream buffer slots.
//   An input is granted only while its output still holds a credit.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   en                 allocation enable (existing locks keep running)
//   req_port0..2       route result per input (global.v port codes)
//   flit_valid[i]      input i presents a flit
//   flit_tail[i]       presented flit of input i is a tail
//   credit_ret[o]      downstream of output o freed one slot (0=LOCAL,1=X1,2=Y1)
//   in_grant[i]        input i may transfer a flit this cycle
//   out_busy[o]        output o is locked
//   out_sel0..2        owning input of output o, 2'd3 when free
//   out_fire[o]        a flit crosses output o this cycle

`ifndef EMPTY
`define EMPTY 3'd0
`endif
`ifndef OUT_LOCAL_PORT
`define OUT_LOCAL_PORT 3'd1
`endif
`ifndef OUT_X1_PORT
`define OUT_X1_PORT 3'd2
`endif
`ifndef OUT_Y1_PORT
`define OUT_Y1_PORT 3'd3
`endif

module router_alloc_3port #(
  parameter int CREDIT_MAX = 4,
  parameter int CW         = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] req_port0,
  input  logic [2:0] req_port1,
  input  logic [2:0] req_port2,
  input  logic [2:0] flit_valid,
  input  logic [2:0] flit_tail,
  input  logic [2:0] credit_ret,
  output logic [2:0] in_grant,
  output logic [2:0] out_busy,
  output logic [1:0] out_sel0,
  output logic [1:0] out_sel1,
  output logic [1:0] out_sel2,
  output logic [2:0] out_fire
);

  localparam logic [1:0]    SEL_FREE  = 2'd3;
  localparam logic [CW-1:0] CRED_FULL = CW'(CREDIT_MAX);
  localparam logic [CW-1:0] CRED_ONE  = CW'(1);

  logic [2:0]    req_port [3];
  logic [2:0]    busy_q;
  logic [1:0]    sel_q    [3];
  logic [CW-1:0] credit_q [3];
  logic [1:0]    rr_q     [3];

  logic [2:0]    owns_c;
  logic [2:0]    grant_c;
  logic [2:0]    fire_c;
  logic [2:0]    release_c;
  logic [2:0]    alloc_c;
  logic [2:0]    req_mtx  [3];
  logic [2:0]    pick_c   [3];

  assign req_port[0] = req_port0;
  assign req_port[1] = req_port1;
  assign req_port[2] = req_port2;

  // Route code that selects output o.
  function automatic logic [2:0] port_code(input int o);
    case (o)
      0:       port_code = `OUT_LOCAL_PORT;
      1:       port_code = `OUT_X1_PORT;
      default: port_code = `OUT_Y1_PORT;
    endcase
  endfunction

  // Round-robin pick: returns {found, index}; search starts at ptr and
  // wraps mod 3. Scanning the offsets downward lets the nearest one win.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    int         s;
    logic [2:0] res;
    res = {1'b0, SEL_FREE};
    for (int k = 2; k >= 0; k--) begin
      s = int'(ptr) + k;
      if (s >= 3) s = s - 3;
      if (req[s]) res = {1'b1, 2'(s)};
    end
    return res;
  endfunction

  function automatic logic [1:0] wrap_inc(input logic [1:0] w);
    return (w == 2'd2) ? 2'd0 : w + 2'd1;
  endfunction

  // Combinational stage: ownership, grant, fire, release and new winners
  always_comb begin
    owns_c    = '0;
    grant_c   = '0;
    fire_c    = '0;
    release_c = '0;
    alloc_c   = '0;
    for (int o = 0; o < 3; o++) begin
      req_mtx[o] = '0;
      pick_c[o]  = '0;
    end

    for (int o = 0; o < 3; o++) begin
      for (int i = 0; i < 3; i++) begin
        if (busy_q[o] && sel_q[o] == 2'(i)) begin
          owns_c[i] = 1'b1;
          if (credit_q[o] != '0) grant_c[i] = 1'b1;
        end
      end
    end

    // An input owns at most one output, so its grant belongs to that output.
    for (int o = 0; o < 3; o++) begin
      for (int i = 0; i < 3; i++) begin
        if (busy_q[o] && sel_q[o] == 2'(i) && grant_c[i] && flit_valid[i]) begin
          fire_c[o]    = 1'b1;
          release_c[o] = flit_tail[i];
        end
      end
    end

    // Owners are excluded; each input names one route code, so the request
    // columns of different outputs never share an input.
    for (int o = 0; o < 3; o++) begin
      for (int i = 0; i < 3; i++) begin
        req_mtx[o][i] = !owns_c[i] && (req_port[i] == port_code(o));
      end
      pick_c[o]  = rr_pick(req_mtx[o], rr_q[o]);
      alloc_c[o] = en && !busy_q[o] && pick_c[o][2];
    end
  end

  // Register stage: locks, round-robin pointers, credit counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int o = 0; o < 3; o++) begin
        sel_q[o]    <= SEL_FREE;
        credit_q[o] <= CRED_FULL;
        rr_q[o]     <= 2'd0;
      end
    end else begin
      for (int o = 0; o < 3; o++) begin
        if (release_c[o]) begin
          busy_q[o] <= 1'b0;
          sel_q[o]  <= SEL_FREE;
        end else if (alloc_c[o]) begin
          busy_q[o] <= 1'b1;
          sel_q[o]  <= pick_c[o][1:0];
          rr_q[o]   <= wrap_inc(pick_c[o][1:0]);
        end

        // A return and a fire in the same cycle cancel out.
        if (credit_ret[o] && !fire_c[o]) begin
          if (credit_q[o] != CRED_FULL) credit_q[o] <= credit_q[o] + CRED_ONE;
        end else if (fire_c[o] && !credit_ret[o]) begin
          credit_q[o] <= credit_q[o] - CRED_ONE;
        end
      end
    end
  end

  assign in_grant = grant_c;
  assign out_fire = fire_c;
  assign out_busy = busy_q;
  assign out_sel0 = sel_q[0];
  assign out_sel1 = sel_q[1];
  assign out_sel2 = sel_q[2];

endmodule

// File: doc/router_alloc_3port.md
ROUTER_ALLOC_3PORT -- requirements
Module: router_alloc_3port

Interface
REQ-001 SHALL have parameter CREDIT_MAX, default 4, meaning downstream buffer depth per output in flits (range 1..7).
REQ-002 SHALL have parameter CW, default 3, meaning credit counter width (must hold CREDIT_MAX).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  allocation enable; gates new allocations only.
REQ-006 req_port0, req_port1, req_port2  input  3 each  route result of input i, coded with global.v macros `EMPTY, `OUT_LOCAL_PORT, `OUT_X1_PORT, `OUT_Y1_PORT.
REQ-007 flit_valid  input  3  bit i: input i presents a flit this cycle.
REQ-008 flit_tail  input  3  bit i: presented flit of input i is a tail flit.
REQ-009 credit_ret  input  3  bit o: downstream of output o freed one buffer slot (o: 0=LOCAL, 1=X1, 2=Y1).
REQ-010 in_grant  output  3  bit i: input i may transfer a flit this cycle.
REQ-011 out_busy  output  3  bit o: output o is locked to an input.
REQ-012 out_sel0, out_sel1, out_sel2  output  2 each  owning input index of output o; 2'd3 when free.
REQ-013 out_fire  output  3  bit o: a flit crosses output o this cycle.

Function
REQ-014 Request decode SHALL use equality against the global.v macros only; `EMPTY or any non-matching code SHALL be treated as no request.
REQ-015 An input already owning an output SHALL NOT be considered for allocation; its req_port is ignored.
REQ-016 At each edge with en=1, every free output o SHALL be allocated to one requesting input, chosen round-robin starting at rr_ptr[o]; out_busy[o], out_sel_o, and rr_ptr[o] = (winner+1) mod 3 update at that edge.
REQ-017 Allocation latency SHALL be one cycle: request present in cycle N -> out_busy high in cycle N+1.
REQ-018 With en=0, no new allocation SHALL occur; existing locks, grants, credits continue operating.
REQ-019 in_grant[i] SHALL be combinational: 1 iff some output o has out_busy[o]=1, out_sel_o=i, credit[o]!=0.
REQ-020 out_fire[o] SHALL equal in_grant[owner] & flit_valid[owner] for busy outputs, else 0.
REQ-021 Per-output credit counter: +1 on credit_ret, -1 on out_fire, unchanged when both in the same cycle.
REQ-022 Credit increment at CREDIT_MAX SHALL be ignored (saturate); decrement at 0 cannot occur since in_grant is low.
REQ-023 When out_fire[o] occurs with flit_tail[owner]=1, output o SHALL be released at that edge (out_busy=0, out_sel=2'd3); it becomes allocatable at the following edge, giving a one-cycle gap between packets.
REQ-024 Single-flit packets (head=tail) SHALL be allocated, fire once, and release as in REQ-023.
REQ-025 rr_ptr[o] SHALL NOT change when no allocation happens on o.
REQ-026 No input SHALL ever own more than one output; no output more than one input.

Reset
REQ-027 On rst_n low, immediately: out_busy=3'b000, out_sel0..2=2'd3, credit counters=CREDIT_MAX, rr_ptr=0 for all outputs, so in_grant=0, out_fire=0.
REQ-028 Reset asserted mid-packet SHALL abandon all locks; after release, behaviour is identical to power-up.

Verification
REQ-029 Single request: req_port1=`OUT_X1_PORT in cycle 0 -> out_busy=3'b010, out_sel1=1, in_grant=3'b010 in cycle 1.
REQ-030 Contention: inputs 0,1,2 all request `OUT_Y1_PORT, each sends 1-flit tail packets -> Y1 granted in order 0,1,2, each separated by one idle cycle.
REQ-031 Credit exhaustion: CREDIT_MAX=4, 6-flit packet, no credit_ret -> 4 fires, in_grant drops, out_busy stays 1; one credit_ret -> exactly one more fire.
REQ-032 Simultaneous credit_ret and out_fire with credit=2 -> credit stays 2; credit_ret at credit=4 -> stays 4.
REQ-033 en=0 with pending request -> no allocation; en=1 -> allocation next edge.
REQ-034 rst_n low during a 3-flit packet after flit 2 -> outputs at reset values immediately; credits return to 4.
